// File: rtl/seg_msg_ctrl.sv
// Display controller for an 8-digit 7-segment scanner: scrolling character buffer
// plus timed status messages, with the buffer restored once a message expires.
module seg_msg_ctrl #(
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_char_valid,
   input  logic [5:0]  i_char_code,
   output logic        o_char_ready,
   input  logic        i_msg_valid,
   input  logic [1:0]  i_msg_sel,
   output logic        o_msg_ready,
   output logic [63:0] o_seg_data,
   output logic [3:0]  o_char_cnt,
   output logic        o_busy
);

   localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
   localparam logic [5:0] CodeBlank = 6'd63;

   typedef enum logic {StIdle, StMsgHold} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_hold_cnt;
   logic [7:0][5:0] r_buf;
   logic [3:0]      r_char_cnt;
   logic [63:0]     r_seg;

   logic            w_idle;
   logic            w_msg_ready;
   logic            w_char_ready;
   logic            w_msg_acc;
   logic            w_char_acc;
   logic [7:0][5:0] w_buf_next;
   logic [63:0]     w_font_seg;
   logic [63:0]     w_msg_pat;

   function automatic logic [7:0] f_font(input logic [5:0] code);
      logic [7:0] seg;
      unique case (code)
         6'd0:  seg = 8'h3F;
         6'd1:  seg = 8'h06;
         6'd2:  seg = 8'h5B;
         6'd3:  seg = 8'h4F;
         6'd4:  seg = 8'h66;
         6'd5:  seg = 8'h6D;
         6'd6:  seg = 8'h7D;
         6'd7:  seg = 8'h07;
         6'd8:  seg = 8'h7F;
         6'd9:  seg = 8'h6F;
         6'd10: seg = 8'h77; // A
         6'd11: seg = 8'h7C; // b
         6'd12: seg = 8'h39; // C
         6'd13: seg = 8'h5E; // d
         6'd14: seg = 8'h79; // E
         6'd15: seg = 8'h71; // F
         6'd16: seg = 8'h3D; // G
         6'd17: seg = 8'h76; // H
         6'd18: seg = 8'h30; // I
         6'd19: seg = 8'h1E; // J
         6'd20: seg = 8'h75; // K
         6'd21: seg = 8'h38; // L
         6'd22: seg = 8'h37; // M
         6'd23: seg = 8'h54; // n
         6'd24: seg = 8'h5C; // o
         6'd25: seg = 8'h73; // P
         6'd26: seg = 8'h67; // q
         6'd27: seg = 8'h50; // r
         6'd28: seg = 8'h6D; // S
         6'd29: seg = 8'h78; // t
         6'd30: seg = 8'h3E; // U
         6'd31: seg = 8'h1C; // v
         6'd32: seg = 8'h2A; // W
         6'd33: seg = 8'h76; // X
         6'd34: seg = 8'h6E; // y
         6'd35: seg = 8'h5B; // Z
         6'd63: seg = 8'h00;
         default: seg = 8'h40; // unknown codes show a dash
      endcase
      return seg;
   endfunction

   assign w_idle       = (r_state == StIdle);
   assign w_msg_ready  = w_idle & ~i_rst & ~i_clr;
   assign w_char_ready = w_msg_ready & ~i_msg_valid;
   assign w_msg_acc    = w_msg_ready & i_msg_valid;
   assign w_char_acc   = w_char_ready & i_char_valid;

   // Outside a char accept this is the current buffer, which is what a message exit restores.
   assign w_buf_next = w_char_acc ? {r_buf[6:0], i_char_code} : r_buf;

   always_comb begin
      w_font_seg = '0;
      for (int i = 0; i < 8; i++) begin
         w_font_seg[i*8 +: 8] = f_font(w_buf_next[i]);
      end
   end

   always_comb begin
      w_msg_pat = '0;
      unique case (i_msg_sel)
         2'd0: w_msg_pat = 64'h0000_0000_0079_5050;
         2'd1: w_msg_pat = 64'h0000_0000_0039_3850;
         2'd2: w_msg_pat = 64'h0000_0000_713E_3838;
         2'd3: w_msg_pat = 64'h0000_0000_5E5C_5479;
         default: w_msg_pat = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_state    <= StIdle;
         r_hold_cnt <= '0;
         r_buf      <= {8{CodeBlank}};
         r_char_cnt <= '0;
         r_seg      <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_msg_acc) begin
                  r_state    <= StMsgHold;
                  r_seg      <= w_msg_pat;
                  r_hold_cnt <= HoldLoad;
               end else if (w_char_acc) begin
                  r_buf <= w_buf_next;
                  r_seg <= w_font_seg;
                  if (r_char_cnt != 4'd8) begin
                     r_char_cnt <= r_char_cnt + 4'd1;
                  end
               end
            end
            StMsgHold: begin
               if (r_hold_cnt == '0) begin
                  r_state <= StIdle;
                  r_seg   <= w_font_seg;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_msg_ready  = w_msg_ready;
   assign o_char_ready = w_char_ready;
   assign o_seg_data   = r_seg;
   assign o_char_cnt   = r_char_cnt;
   assign o_busy       = (r_state == StMsgHold);

endmodule

// File: tb/tb_seg_msg_ctrl.sv
// Directed bench for seg_msg_ctrl with a short hold time; expected patterns are hand-computed.
module tb_seg_msg_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        char_valid = 1'b0;
   logic [5:0]  char_code = '0;
   logic        char_ready;
   logic        msg_valid = 1'b0;
   logic [1:0]  msg_sel = '0;
   logic        msg_ready;
   logic [63:0] seg_data;
   logic [3:0]  char_cnt;
   logic        busy;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] PatErr  = 64'h0000_0000_0079_5050;
   localparam logic [63:0] PatClr  = 64'h0000_0000_0039_3850;
   localparam logic [63:0] PatFull = 64'h0000_0000_713E_3838;
   localparam logic [63:0] PatDone = 64'h0000_0000_5E5C_5479;
   localparam logic [63:0] Buf123  = 64'h0000_0000_0006_5B4F;

   seg_msg_ctrl #(.HOLD_CYCLES(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clr        (clr),
      .i_char_valid (char_valid),
      .i_char_code  (char_code),
      .o_char_ready (char_ready),
      .i_msg_valid  (msg_valid),
      .i_msg_sel    (msg_sel),
      .o_msg_ready  (msg_ready),
      .o_seg_data   (seg_data),
      .o_char_cnt   (char_cnt),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic append(input logic [5:0] code);
      char_valid = 1'b1;
      char_code  = code;
      #1;
      total++;
      if (char_ready !== 1'b1) begin
         bad++;
         $display("FAIL append_ready code=%0d got=%b want=1", code, char_ready);
      end
      step();
      char_valid = 1'b0;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      char_valid = 1'b1;
      msg_valid  = 1'b1;
      step();
      total++;
      if ({seg_data, char_cnt, busy} !== {64'h0, 4'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state seg=%h cnt=%0d busy=%b want 0/0/0", seg_data, char_cnt, busy);
      end
      total++;
      if ({char_ready, msg_ready} !== 2'b00) begin
         bad++;
         $display("FAIL reset_ready got=%b want=00", {char_ready, msg_ready});
      end
      char_valid = 1'b0;
      msg_valid  = 1'b0;
      rst        = 1'b0;
      step();
   endtask

   task automatic test_append();
      append(6'd1);
      total++;
      if (seg_data !== 64'h0000_0000_0000_0006) begin
         bad++;
         $display("FAIL append_latency got=%h want=%h", seg_data, 64'h6);
      end
      append(6'd2);
      append(6'd3);
      total++;
      if (seg_data !== Buf123 || char_cnt !== 4'd3) begin
         bad++;
         $display("FAIL append_123 seg=%h cnt=%0d want=%h/3", seg_data, char_cnt, Buf123);
      end
   endtask

   task automatic test_back_to_back();
      do_clear();
      char_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         char_code = 6'(i);
         #1;
         total++;
         if (char_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready i=%0d got=%b want=1", i, char_ready);
         end
         step();
      end
      char_valid = 1'b0;
      total++;
      if (seg_data !== 64'h065B_4F66_6D7D_077F || char_cnt !== 4'd8) begin
         bad++;
         $display("FAIL b2b_scroll seg=%h cnt=%0d want=065b4f666d7d077f/8", seg_data, char_cnt);
      end
      append(6'd35);
      total++;
      if (seg_data !== 64'h5B4F_666D_7D07_7F5B || char_cnt !== 4'd8) begin
         bad++;
         $display("FAIL b2b_saturate seg=%h cnt=%0d want=5b4f666d7d077f5b/8", seg_data, char_cnt);
      end
   endtask

   task automatic test_msg_hold();
      do_clear();
      append(6'd1);
      append(6'd2);
      append(6'd3);
      msg_valid = 1'b1;
      msg_sel   = 2'd0;
      #1;
      total++;
      if (msg_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_msg_ready got=%b want=1", msg_ready);
      end
      step();
      msg_valid  = 1'b0;
      char_valid = 1'b1;  // offered during the hold; must not be taken
      char_code  = 6'd9;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (seg_data !== PatErr || busy !== 1'b1 || {char_ready, msg_ready} !== 2'b00) begin
            bad++;
            $display("FAIL hold_cycle k=%0d seg=%h busy=%b rdy=%b want=%h/1/00",
                     k, seg_data, busy, {char_ready, msg_ready}, PatErr);
         end
         step();
      end
      char_valid = 1'b0;
      total++;
      if (seg_data !== Buf123 || busy !== 1'b0 || char_cnt !== 4'd3) begin
         bad++;
         $display("FAIL hold_restore seg=%h busy=%b cnt=%0d want=%h/0/3",
                  seg_data, busy, char_cnt, Buf123);
      end
   endtask

   task automatic test_arbitration();
      char_valid = 1'b1;
      char_code  = 6'd10;
      msg_valid  = 1'b1;
      msg_sel    = 2'd3;
      #1;
      total++;
      if ({msg_ready, char_ready} !== 2'b10) begin
         bad++;
         $display("FAIL arb_ready got=%b want=10", {msg_ready, char_ready});
      end
      step();
      msg_valid = 1'b0;
      total++;
      if (seg_data !== PatDone || busy !== 1'b1) begin
         bad++;
         $display("FAIL arb_msg seg=%h busy=%b want=%h/1", seg_data, busy, PatDone);
      end
      for (int k = 0; k < 4; k++) step();
      total++;
      if (seg_data !== Buf123 || char_ready !== 1'b1 || char_cnt !== 4'd3) begin
         bad++;
         $display("FAIL arb_after_hold seg=%h rdy=%b cnt=%0d want=%h/1/3",
                  seg_data, char_ready, char_cnt, Buf123);
      end
      step();
      char_valid = 1'b0;
      total++;
      if (seg_data !== 64'h0000_0006_5B4F_77 || char_cnt !== 4'd4) begin
         bad++;
         $display("FAIL arb_char seg=%h cnt=%0d want=000000065b4f77/4", seg_data, char_cnt);
      end
   endtask

   task automatic test_clr_hold();
      msg_valid = 1'b1;
      msg_sel   = 2'd1;
      step();
      msg_valid = 1'b0;
      total++;
      if (seg_data !== PatClr) begin
         bad++;
         $display("FAIL clr_msg seg=%h want=%h", seg_data, PatClr);
      end
      step();
      clr = 1'b1;
      step();
      total++;
      if (busy !== 1'b0 || seg_data !== 64'h0 || char_cnt !== 4'd0) begin
         bad++;
         $display("FAIL clr_abort busy=%b seg=%h cnt=%0d want=0/0/0", busy, seg_data, char_cnt);
      end
      // clr still high in IDLE: both requesters blocked
      char_valid = 1'b1;
      char_code  = 6'd4;
      msg_valid  = 1'b1;
      #1;
      total++;
      if ({char_ready, msg_ready} !== 2'b00) begin
         bad++;
         $display("FAIL clr_ready got=%b want=00", {char_ready, msg_ready});
      end
      step();
      char_valid = 1'b0;
      msg_valid  = 1'b0;
      clr        = 1'b0;
      total++;
      if (busy !== 1'b0 || char_cnt !== 4'd0 || seg_data !== 64'h0) begin
         bad++;
         $display("FAIL clr_block busy=%b cnt=%0d seg=%h want=0/0/0", busy, char_cnt, seg_data);
      end
   endtask

   task automatic test_rst_hold();
      append(6'd5);
      msg_valid = 1'b1;
      msg_sel   = 2'd2;
      step();
      msg_valid = 1'b0;
      total++;
      if (seg_data !== PatFull) begin
         bad++;
         $display("FAIL rst_msg seg=%h want=%h", seg_data, PatFull);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || seg_data !== 64'h0 || char_cnt !== 4'd0) begin
         bad++;
         $display("FAIL rst_abort busy=%b seg=%h cnt=%0d want=0/0/0", busy, seg_data, char_cnt);
      end
      append(6'd40);
      total++;
      if (seg_data !== 64'h40) begin
         bad++;
         $display("FAIL rst_unknown seg=%h want=%h", seg_data, 64'h40);
      end
      append(6'd63);
      total++;
      if (seg_data !== 64'h4000 || char_cnt !== 4'd2) begin
         bad++;
         $display("FAIL rst_blank seg=%h cnt=%0d want=%h/2", seg_data, char_cnt, 64'h4000);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_append();
      test_back_to_back();
      test_msg_hold();
      test_arbitration();
      test_clr_hold();
      test_rst_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
